// File: rtl/ibex_hpm_counters.sv
// Machine cycle/instret counters plus NumCounters programmable event counters with CSR access.
// Define IBEX_HPM_OVERFLOW_EN to build sticky per-counter overflow flags on ovf_o.
module ibex_hpm_counters #(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  localparam int unsigned NumOvf      = (NumCounters > 0) ? NumCounters : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_access_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [1:0]           csr_op_i,
  input  logic [31:0]          csr_wdata_i,
  input  logic                 csr_we_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_illegal_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  output logic [NumOvf-1:0]    ovf_o
);

  localparam logic [1:0] OpRead  = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpSet   = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  function automatic logic [31:0] inhibit_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int k = 0; k < int'(NumCounters); k++) m[k+3] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] InhibitMask = inhibit_mask();

  logic [63:0]             r_mcycle;
  logic [63:0]             r_minstret;
  logic [31:0]             r_inhibit;
  logic [NumEvents-1:0]    r_event [NumOvf];
  logic [CounterWidth-1:0] r_hpm   [NumOvf];

  logic [4:0]  w_idx;
  logic        w_sel_inh, w_sel_evt, w_sel_lo, w_sel_hi;
  logic        w_wr;
  logic [31:0] w_rdata;
  logic [31:0] w_new;
  logic [NumOvf-1:0] w_hit, w_inc, w_wlo, w_whi, w_wevt;

  assign w_idx     = csr_addr_i[4:0];
  assign w_sel_inh = (csr_addr_i == 12'h320);
  assign w_sel_evt = ((csr_addr_i & 12'hFE0) == 12'h320) && (w_idx >= 5'd3);
  assign w_sel_lo  = ((csr_addr_i & 12'hFE0) == 12'hB00) && (w_idx != 5'd1);
  assign w_sel_hi  = ((csr_addr_i & 12'hFE0) == 12'hB80) && (w_idx != 5'd1);
  assign w_wr      = csr_access_i & csr_we_i & (csr_op_i != OpRead);

  assign csr_illegal_o = csr_access_i & ~(w_sel_inh | w_sel_evt | w_sel_lo | w_sel_hi);
  assign csr_rdata_o   = w_rdata;

  // Read mux; unimplemented counter indices fall through as zero.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_sel_inh) begin
      w_rdata = r_inhibit;
    end else if (w_sel_evt) begin
      for (int k = 0; k < int'(NumCounters); k++) begin
        w_rdata = w_rdata | ((w_idx == 5'(k + 3)) ? 32'(r_event[k]) : 32'h0000_0000);
      end
    end else if (w_sel_lo) begin
      case (w_idx)
        5'd0:    w_rdata = r_mcycle[31:0];
        5'd2:    w_rdata = r_minstret[31:0];
        default: begin
          for (int k = 0; k < int'(NumCounters); k++) begin
            w_rdata = w_rdata | ((w_idx == 5'(k + 3)) ? r_hpm[k][31:0] : 32'h0000_0000);
          end
        end
      endcase
    end else if (w_sel_hi) begin
      case (w_idx)
        5'd0:    w_rdata = r_mcycle[63:32];
        5'd2:    w_rdata = r_minstret[63:32];
        default: begin
          for (int k = 0; k < int'(NumCounters); k++) begin
            w_rdata = w_rdata |
                      ((w_idx == 5'(k + 3)) ? 32'(r_hpm[k][CounterWidth-1:32]) : 32'h0000_0000);
          end
        end
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Read-modify-write operand is the 32-bit view just read, so field masking happens at the store.
  always_comb begin
    case (csr_op_i)
      OpWrite: w_new = csr_wdata_i;
      OpSet:   w_new = w_rdata | csr_wdata_i;
      OpClear: w_new = w_rdata & ~csr_wdata_i;
      default: w_new = w_rdata;
    endcase
  end

  // Per-counter address hits, write strobes and increment qualifiers.
  always_comb begin
    w_hit  = {NumOvf{1'b0}};
    w_inc  = {NumOvf{1'b0}};
    w_wlo  = {NumOvf{1'b0}};
    w_whi  = {NumOvf{1'b0}};
    w_wevt = {NumOvf{1'b0}};
    for (int k = 0; k < int'(NumCounters); k++) begin
      w_hit[k]  = (w_idx == 5'(k + 3));
      w_inc[k]  = (|(event_i & r_event[k])) & ~r_inhibit[k+3];
      w_wlo[k]  = w_wr & w_sel_lo & w_hit[k];
      w_whi[k]  = w_wr & w_sel_hi & w_hit[k];
      w_wevt[k] = w_wr & w_sel_evt & w_hit[k];
    end
  end

  // Fixed 64-bit counters; a write to either half suppresses that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      if (w_wr && w_sel_lo && (w_idx == 5'd0)) begin
        r_mcycle[31:0] <= w_new;
      end else if (w_wr && w_sel_hi && (w_idx == 5'd0)) begin
        r_mcycle[63:32] <= w_new;
      end else if (!r_inhibit[0]) begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_wr && w_sel_lo && (w_idx == 5'd2)) begin
        r_minstret[31:0] <= w_new;
      end else if (w_wr && w_sel_hi && (w_idx == 5'd2)) begin
        r_minstret[63:32] <= w_new;
      end else if (instr_ret_i && !r_inhibit[2]) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end

  // Inhibit register; the stored value gates increments from the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inhibit <= 32'h0000_0000;
    end else if (w_wr && w_sel_inh) begin
      r_inhibit <= w_new & InhibitMask;
    end
  end

  // Programmable event selectors and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NumOvf); k++) begin
        r_event[k] <= {NumEvents{1'b0}};
        r_hpm[k]   <= {CounterWidth{1'b0}};
      end
    end else begin
      for (int k = 0; k < int'(NumCounters); k++) begin
        if (w_wevt[k]) r_event[k] <= w_new[NumEvents-1:0];
        if (w_wlo[k]) begin
          r_hpm[k][31:0] <= w_new;
        end else if (w_whi[k]) begin
          r_hpm[k][CounterWidth-1:32] <= w_new[CounterWidth-33:0];
        end else if (w_inc[k]) begin
          r_hpm[k] <= r_hpm[k] + {{(CounterWidth-1){1'b0}}, 1'b1};
        end
      end
    end
  end

`ifdef IBEX_HPM_OVERFLOW_EN
  logic [NumOvf-1:0] r_ovf;

  // Sticky wrap flags; any write to the counter clears its flag and wins over a wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= {NumOvf{1'b0}};
    end else begin
      for (int k = 0; k < int'(NumCounters); k++) begin
        if (w_wlo[k] || w_whi[k]) begin
          r_ovf[k] <= 1'b0;
        end else if (w_inc[k] && (&r_hpm[k])) begin
          r_ovf[k] <= 1'b1;
        end
      end
    end
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = {NumOvf{1'b0}};
`endif

endmodule

// File: tb/tb_ibex_hpm_counters.sv
// Directed self-checking bench for ibex_hpm_counters at default parameters.
module tb_ibex_hpm_counters;

  logic        clk;
  logic        rst_ni;
  logic        csr_access_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic        csr_we_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        instr_ret_i;
  logic [15:0] event_i;
  logic [7:0]  ovf_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IBEX_HPM_OVERFLOW_EN
  localparam logic [7:0] ExpOvfWrap = 8'h01;
`else
  localparam logic [7:0] ExpOvfWrap = 8'h00;
`endif

  ibex_hpm_counters dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .csr_access_i  (csr_access_i),
    .csr_addr_i    (csr_addr_i),
    .csr_op_i      (csr_op_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_we_i      (csr_we_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o),
    .instr_ret_i   (instr_ret_i),
    .event_i       (event_i),
    .ovf_o         (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                           output logic [31:0] old);
    csr_access_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = a; csr_op_i = op; csr_wdata_i = d;
    #1 old = csr_rdata_o;
    @(posedge clk); #1;
    csr_access_i = 1'b0; csr_we_i = 1'b0; csr_op_i = 2'd0; csr_wdata_i = 32'h0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    csr_access_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = a; csr_op_i = 2'd0;
    #1 d = csr_rdata_o; ill = csr_illegal_o;
    csr_access_i = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic ill;
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_mcycle: got %h expected %h", d, 32'h0); end
    csr_read(12'hB03, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_hpm3: got %h expected %h", d, 32'h0); end
    n_checks++; if (ovf_o !== 8'h00) begin n_errors++; $display("FAIL reset_ovf: got %h expected %h", ovf_o, 8'h00); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic_count;
    logic [31:0] d; logic ill;
    for (int i = 0; i < 10; i++) begin
      instr_ret_i = (i % 2 == 0);
      @(posedge clk); #1;
    end
    instr_ret_i = 1'b0;
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'd10) begin n_errors++; $display("FAIL mcycle_10: got %0d expected %0d", d, 10); end
    n_checks++; if (ill !== 1'b0) begin n_errors++; $display("FAIL mcycle_legal: got %b expected %b", ill, 1'b0); end
    csr_read(12'hB02, d, ill);
    n_checks++; if (d !== 32'd5) begin n_errors++; $display("FAIL minstret_5: got %0d expected %0d", d, 5); end
    csr_read(12'hB80, d, ill);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL mcycleh_0: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_event_count;
    logic [31:0] d, old; logic ill;
    csr_write(12'h323, 2'd1, 32'h3, old);
    event_i = 16'h0003; tick(4);
    event_i = 16'h0004; tick(4);
    event_i = 16'h0000;
    csr_read(12'hB03, d, ill);
    n_checks++; if (d !== 32'd4) begin n_errors++; $display("FAIL hpm3_events: got %0d expected %0d", d, 4); end
    csr_read(12'h323, d, ill);
    n_checks++; if (d !== 32'h3) begin n_errors++; $display("FAIL evt3_read: got %h expected %h", d, 32'h3); end
    csr_write(12'h324, 2'd1, 32'hFFFF_FFFF, old);
    csr_read(12'h324, d, ill);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_errors++; $display("FAIL evt4_mask: got %h expected %h", d, 32'h0000_FFFF); end
    csr_write(12'h324, 2'd3, 32'h1, old);
    csr_read(12'h324, d, ill);
    n_checks++; if (d !== 32'h0000_FFFE) begin n_errors++; $display("FAIL evt4_clear: got %h expected %h", d, 32'h0000_FFFE); end
    csr_write(12'h323, 2'd2, 32'h0001_0000, old);
    csr_read(12'h323, d, ill);
    n_checks++; if (d !== 32'h3) begin n_errors++; $display("FAIL evt3_set_hi: got %h expected %h", d, 32'h3); end
  endtask

  task automatic test_wrap;
    logic [31:0] d, old; logic ill;
    csr_write(12'hB83, 2'd1, 32'h0000_01FF, old);
    csr_write(12'hB03, 2'd1, 32'hFFFF_FFFF, old);
    csr_read(12'hB83, d, ill);
    n_checks++; if (d !== 32'hFF) begin n_errors++; $display("FAIL hpm3h_trunc: got %h expected %h", d, 32'hFF); end
    event_i = 16'h0001; tick(1); event_i = 16'h0000;
    csr_read(12'hB03, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL wrap_lo: got %h expected %h", d, 32'h0); end
    csr_read(12'hB83, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL wrap_hi: got %h expected %h", d, 32'h0); end
    n_checks++; if (ovf_o !== ExpOvfWrap) begin n_errors++; $display("FAIL wrap_ovf: got %h expected %h", ovf_o, ExpOvfWrap); end
    csr_write(12'hB03, 2'd1, 32'h0, old);
    n_checks++; if (ovf_o !== 8'h00) begin n_errors++; $display("FAIL ovf_clear: got %h expected %h", ovf_o, 8'h00); end
  endtask

  task automatic test_inhibit;
    logic [31:0] d, old; logic ill;
    csr_write(12'hB80, 2'd1, 32'h0, old);
    csr_write(12'hB00, 2'd1, 32'h0000_1000, old);
    csr_write(12'h320, 2'd2, 32'h1, old);
    tick(5);
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'h0000_1001) begin n_errors++; $display("FAIL inhibit_hold: got %h expected %h", d, 32'h0000_1001); end
    csr_read(12'h320, d, ill);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL inhibit_read: got %h expected %h", d, 32'h1); end
    csr_write(12'h320, 2'd3, 32'h1, old);
    tick(3);
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'h0000_1004) begin n_errors++; $display("FAIL inhibit_resume: got %h expected %h", d, 32'h0000_1004); end
    csr_write(12'h320, 2'd1, 32'hFFFF_FFFF, old);
    csr_read(12'h320, d, ill);
    n_checks++; if (d !== 32'h0000_07FD) begin n_errors++; $display("FAIL inhibit_mask: got %h expected %h", d, 32'h0000_07FD); end
    csr_write(12'h320, 2'd1, 32'h0, old);
  endtask

  task automatic test_write_priority;
    logic [31:0] d, old; logic ill;
    event_i = 16'h0004; tick(2);
    csr_write(12'hB04, 2'd1, 32'h0000_0100, old);
    event_i = 16'h0000;
    n_checks++; if (old !== 32'd2) begin n_errors++; $display("FAIL prio_old: got %h expected %h", old, 32'd2); end
    csr_read(12'hB04, d, ill);
    n_checks++; if (d !== 32'h0000_0100) begin n_errors++; $display("FAIL prio_new: got %h expected %h", d, 32'h0000_0100); end
    csr_read(12'hB84, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL prio_hi: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_illegal;
    logic [31:0] d, old; logic ill;
    csr_read(12'hB01, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_errors++; $display("FAIL ill_b01: got %b expected %b", ill, 1'b1); end
    csr_read(12'h7C0, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_errors++; $display("FAIL ill_7c0: got %b expected %b", ill, 1'b1); end
    csr_read(12'h321, d, ill);
    n_checks++; if (ill !== 1'b1) begin n_errors++; $display("FAIL ill_321: got %b expected %b", ill, 1'b1); end
    csr_access_i = 1'b0; csr_addr_i = 12'h7C0; #1;
    n_checks++; if (csr_illegal_o !== 1'b0) begin n_errors++; $display("FAIL ill_noaccess: got %b expected %b", csr_illegal_o, 1'b0); end
    @(posedge clk); #1;
    csr_write(12'hB1F, 2'd1, 32'h1234, old);
    csr_read(12'hB1F, d, ill);
    n_checks++; if (ill !== 1'b0) begin n_errors++; $display("FAIL ill_b1f: got %b expected %b", ill, 1'b0); end
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL rd_b1f: got %h expected %h", d, 32'h0); end
    csr_read(12'h33F, d, ill);
    n_checks++; if ((ill !== 1'b0) || (d !== 32'h0)) begin n_errors++; $display("FAIL evt_33f: got ill=%b d=%h expected ill=0 d=0", ill, d); end
  endtask

  task automatic test_async_reset;
    logic [31:0] d, old; logic ill;
    csr_write(12'hB05, 2'd1, 32'h55, old);
    csr_read(12'hB05, d, ill);
    n_checks++; if (d !== 32'h55) begin n_errors++; $display("FAIL hpm5_write: got %h expected %h", d, 32'h55); end
    @(posedge clk); #1;
    csr_access_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'hB05; csr_op_i = 2'd1; csr_wdata_i = 32'h77;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (csr_rdata_o !== 32'h0) begin n_errors++; $display("FAIL async_clear: got %h expected %h", csr_rdata_o, 32'h0); end
    @(posedge clk); #1;
    csr_access_i = 1'b0; csr_we_i = 1'b0; csr_op_i = 2'd0; csr_wdata_i = 32'h0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL post_rst_0: got %h expected %h", d, 32'h0); end
    @(posedge clk); #1;
    csr_read(12'hB00, d, ill);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL post_rst_1: got %h expected %h", d, 32'h1); end
    csr_read(12'hB05, d, ill);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL rst_discard: got %h expected %h", d, 32'h0); end
  endtask

  initial begin
    rst_ni = 1'b0; csr_access_i = 1'b0; csr_addr_i = 12'h0; csr_op_i = 2'd0;
    csr_wdata_i = 32'h0; csr_we_i = 1'b0; instr_ret_i = 1'b0; event_i = 16'h0;
    #1;
    test_reset;
    test_basic_count;
    test_event_count;
    test_wrap;
    test_inhibit;
    test_write_priority;
    test_illegal;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_hpm_counters.md
IBEX_HPM_COUNTERS -- requirements
Module: ibex_hpm_counters

Interface
REQ-001 SHALL have parameter NumCounters, default 8, number of programmable counters mhpmcounter3..(3+NumCounters-1); legal range 0..29.
REQ-002 SHALL have parameter CounterWidth, default 40, implemented width of each programmable counter; legal range 33..64.
REQ-003 SHALL have parameter NumEvents, default 16, width of event input vector; legal range 1..32.
REQ-004 clk_i  input  1  core clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 csr_access_i  input  1  CSR instruction in ID this cycle.
REQ-007 csr_addr_i  input  12  CSR number (csr_num_e encoding).
REQ-008 csr_op_i  input  2  csr_op_e: READ, WRITE, SET, CLEAR.
REQ-009 csr_wdata_i  input  32  write operand.
REQ-010 csr_we_i  input  1  write strobe; qualified by csr_access_i.
REQ-011 csr_rdata_o  output  32  read data, combinational.
REQ-012 csr_illegal_o  output  1  address not handled by this block, combinational.
REQ-013 instr_ret_i  input  1  one instruction retired this cycle.
REQ-014 event_i  input  NumEvents  per-cycle event pulses.
REQ-015 ovf_o  output  max(NumCounters,1)  sticky per-counter overflow flags.

Function
REQ-016 Decoded CSRs SHALL be: MCOUNTINHIBIT 0x320; MHPMEVENT3.. 0x323..0x33F; MCYCLE 0xB00/MCYCLEH 0xB80; MINSTRET 0xB02/MINSTRETH 0xB82; MHPMCOUNTERk 0xB03..0xB1F; MHPMCOUNTERkH 0xB83..0xB9F (mask 0xFE0 against the three bases).
REQ-017 csr_illegal_o SHALL be 1 iff csr_access_i=1 and csr_addr_i is outside REQ-016, also for 0xB01/0xB81/0x321/0x322.
REQ-018 mcycle, minstret SHALL be 64 bits; mcycle +1 every cycle unless inhibit[0]; minstret +1 when instr_ret_i unless inhibit[2].
REQ-019 Counter k SHALL increment by exactly 1 in a cycle where (event_i & mhpmevent_k[NumEvents-1:0]) != 0 and inhibit[k]=0; multiple matching events still add 1.
REQ-020 mhpmevent_k bits >= NumEvents SHALL read 0 and ignore writes; inhibit bit 1 and bits >= 3+NumCounters SHALL read 0.
REQ-021 Unimplemented counter indices (k >= 3+NumCounters) SHALL read 0, ignore writes, and not raise csr_illegal_o.
REQ-022 Write SHALL occur when csr_access_i & csr_we_i & op != READ; new = WRITE: wdata; SET: old|wdata; CLEAR: old&~wdata.
REQ-023 Low-half write SHALL change bits [31:0] only; high-half write SHALL change bits [W-1:32] only, discarding wdata bits beyond W.
REQ-024 High-half read SHALL return bits [W-1:32] zero-extended to 32.
REQ-025 csr_rdata_o SHALL reflect pre-write register value in the write cycle; new value visible next cycle.
REQ-026 A CSR write to a counter SHALL take priority over its increment in the same cycle; written value stored exactly, no +1 applied.
REQ-027 Counter at all-ones (W bits) incrementing SHALL wrap to 0.
REQ-028 Writing MCOUNTINHIBIT SHALL affect increments from the next cycle, not the write cycle.

Reset
REQ-029 On rst_ni=0 all counters, mhpmevent, mcountinhibit and ovf_o SHALL clear to 0 immediately, regardless of clock; reset mid-write discards the write.
REQ-030 First increment after reset deassertion SHALL occur on the first rising edge with rst_ni=1.

Configuration
REQ-031 Macro IBEX_HPM_OVERFLOW_EN defined: ovf_o[k] SHALL set on the edge counter k wraps (REQ-027) and clear on any write to counter k's low or high CSR; write wins if same cycle.
REQ-032 Macro undefined: ovf_o SHALL be constant 0, no overflow flops.

Verification
REQ-033 Reset, 10 cycles, instr_ret_i=1 every 2nd cycle -> MCYCLE reads 10, MINSTRET reads 5.
REQ-034 MHPMEVENT3=0x3, event_i=0x3 for 4 cycles then 0x4 for 4 cycles -> MHPMCOUNTER3 reads 4.
REQ-035 Write MHPMCOUNTER3H=0xFF, MHPMCOUNTER3=0xFFFFFFFF (W=40), one matching event -> counter reads 0 both halves, ovf_o[0]=1 (macro on) / 0 (macro off); write MHPMCOUNTER3=0 -> ovf_o[0]=0.
REQ-036 MCOUNTINHIBIT SET 0x1 then 5 cycles -> MCYCLE unchanged after the write cycle; CLEAR 0x1 resumes counting.
REQ-037 Write MHPMCOUNTER4=0x100 in a cycle with its event active -> reads 0x100 next cycle; read in write cycle returns old value.
REQ-038 Access 0xB01, 0x7C0 -> csr_illegal_o=1; access 0xB1F with NumCounters=8 -> csr_illegal_o=0, rdata 0.
